// File: rtl/complex_sched_if.sv
// Request/response bundle between the client blocks and complex_sched.
// The master side belongs to the clients; the slave side belongs to the scheduler.
interface complex_sched_if #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_x;
   logic [8*NREQ-1:0] req_y;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [ID_W-1:0]   rsp_id;
   logic              rsp_out;

   modport master (
      output req_valid, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_out
   );

   modport slave (
      input  req_valid, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_out
   );
endinterface

// File: rtl/complex_sched.sv
// Round-robin scheduler that time-shares one external AND-OR tree among NREQ clients.
// Operands are registered, held for SETTLE cycles, and the sampled result is returned with the owner's ID.
module complex_sched #(
   parameter int NREQ   = 4,
   parameter int ID_W   = 2,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   complex_sched_if.slave        bus,
   output logic [7:0]            eval_x,
   output logic [7:0]            eval_y,
   input  logic                  eval_out,
   output logic                  busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] grant;
   logic            found;
   logic [3:0]      cnt;
   logic            accept;
   logic            capture;
   logic            release_rsp;

   // First valid requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && bus.req_valid[(int'(ptr) + k) % NREQ]) begin
            found = 1'b1;
            grant = ID_W'((int'(ptr) + k) % NREQ);
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      capture       = 1'b0;
      release_rsp   = 1'b0;
      bus.req_ready = '0;
      case (state)
         ST_IDLE: begin
            // Grant is suppressed while reset is held so req_ready reads zero.
            if (found && !rst) begin
               bus.req_ready[grant] = 1'b1;
               accept               = 1'b1;
               state_nxt            = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt == 4'd1) begin
               capture   = 1'b1;
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               release_rsp = 1'b1;
               state_nxt   = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         ptr           <= '0;
         cnt           <= '0;
         eval_x        <= '0;
         eval_y        <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_out   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            eval_x     <= bus.req_x[8*int'(grant) +: 8];
            eval_y     <= bus.req_y[8*int'(grant) +: 8];
            bus.rsp_id <= grant;
            cnt        <= 4'(SETTLE);
         end else if (state == ST_SETTLE) begin
            cnt <= cnt - 4'd1;
         end
         if (capture) begin
            bus.rsp_out   <= eval_out;
            bus.rsp_valid <= 1'b1;
         end
         // Next search starts just after the requester that was served.
         if (release_rsp) begin
            bus.rsp_valid <= 1'b0;
            ptr <= (int'(bus.rsp_id) == NREQ - 1) ? '0 : bus.rsp_id + ID_W'(1);
         end
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_complex_sched.sv
// Bench for complex_sched: transaction-level model checked every cycle on the SETTLE=1 instance,
// plus directed vectors on both a SETTLE=1 and a SETTLE=3 instance.
module tb_complex_sched;

   localparam int NREQ = 4;
   localparam int ID_W = 2;
   localparam int S1   = 1;
   localparam int S3   = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   complex_sched_if #(.NREQ(NREQ), .ID_W(ID_W)) bus1 ();
   complex_sched_if #(.NREQ(NREQ), .ID_W(ID_W)) bus3 ();

   logic [7:0] eval_x1, eval_y1, eval_x3, eval_y3;
   logic       eval_out1, eval_out3, busy1, busy3;

   function automatic logic tree(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      p = x & y;
      return ((|p[1:0]) & (|p[3:2])) | ((|p[5:4]) & (|p[7:6]));
   endfunction

   assign eval_out1 = tree(eval_x1, eval_y1);
   assign eval_out3 = tree(eval_x3, eval_y3);

   complex_sched #(.NREQ(NREQ), .ID_W(ID_W), .SETTLE(S1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1),
      .eval_x(eval_x1), .eval_y(eval_y1), .eval_out(eval_out1), .busy(busy1)
   );

   complex_sched #(.NREQ(NREQ), .ID_W(ID_W), .SETTLE(S3)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3),
      .eval_x(eval_x3), .eval_y(eval_y3), .eval_out(eval_out3), .busy(busy3)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Transaction-level model of the SETTLE=1 instance: who owns the tree and for how many edges.
   int         m_ptr   = 0;
   int         m_owner = -1;
   int         m_age   = 0;
   logic [7:0] m_x     = '0;
   logic [7:0] m_y     = '0;
   int         d_grant = -1;
   bit         d_fire  = 1'b0;

   always @(negedge clk) begin
      logic [NREQ-1:0] exp_ready;
      bit              exp_rv;
      d_grant   = -1;
      d_fire    = 1'b0;
      exp_ready = '0;
      exp_rv    = 1'b0;
      if (!rst) begin
         if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++)
               if (d_grant < 0 && bus1.req_valid[(m_ptr + k) % NREQ]) d_grant = (m_ptr + k) % NREQ;
            if (d_grant >= 0) exp_ready[d_grant] = 1'b1;
         end else begin
            exp_rv = (m_age > S1);
            d_fire = exp_rv && bus1.rsp_ready;
         end
         check("m_req_ready", 32'(bus1.req_ready), 32'(exp_ready));
         check("m_busy", 32'(busy1), 32'(m_owner >= 0));
         check("m_rsp_valid", 32'(bus1.rsp_valid), 32'(exp_rv));
         check("m_eval_x", 32'(eval_x1), 32'(m_x));
         check("m_eval_y", 32'(eval_y1), 32'(m_y));
         if (exp_rv) begin
            check("m_rsp_id", 32'(bus1.rsp_id), 32'(m_owner));
            check("m_rsp_out", 32'(bus1.rsp_out), 32'(tree(m_x, m_y)));
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ptr = 0; m_owner = -1; m_age = 0; m_x = '0; m_y = '0;
      end else if (d_fire) begin
         m_ptr   = (m_owner + 1) % NREQ;
         m_owner = -1;
      end else if (m_owner >= 0) begin
         m_age++;
      end else if (d_grant >= 0) begin
         m_owner = d_grant;
         m_age   = 1;
         m_x     = bus1.req_x[8*d_grant +: 8];
         m_y     = bus1.req_y[8*d_grant +: 8];
      end
   end

   int grant_log[$];
   always @(negedge clk)
      if (!rst && bus1.req_ready != '0)
         for (int i = 0; i < NREQ; i++) if (bus1.req_ready[i]) grant_log.push_back(i);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp1(input string name);
      int n = 0;
      @(negedge clk);
      while (!bus1.rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check(name, 32'(bus1.rsp_valid), 32'd1);
   endtask

   task automatic single(input int idx, input logic [7:0] x, input logic [7:0] y,
                         input logic exp_out, input string name);
      bus1.req_x[8*idx +: 8] = x;
      bus1.req_y[8*idx +: 8] = y;
      bus1.req_valid         = '0;
      bus1.req_valid[idx]    = 1'b1;
      @(negedge clk);
      check({name, "_grant"}, 32'(bus1.req_ready), 32'(1) << idx);
      tick();
      bus1.req_valid = '0;
      @(negedge clk);
      check({name, "_eval_x"}, 32'(eval_x1), 32'(x));
      wait_rsp1({name, "_timeout"});
      check({name, "_id"}, 32'(bus1.rsp_id), 32'(idx));
      check({name, "_out"}, 32'(bus1.rsp_out), 32'(exp_out));
      tick();
      @(negedge clk);
      check({name, "_busy_after"}, 32'(busy1), 32'd0);
      tick();
   endtask

   initial begin
      int n;
      int exp_order[5] = '{0, 1, 2, 3, 0};
      bus1.req_valid = '1; bus1.req_x = '0; bus1.req_y = '0; bus1.rsp_ready = 1'b1;
      bus3.req_valid = '0; bus3.req_x = '0; bus3.req_y = '0; bus3.rsp_ready = 1'b1;

      // Reset values, with every request line raised to show req_ready stays low.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(bus1.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
      check("rst_eval_x", 32'(eval_x1), 32'd0);
      check("rst_rsp_id", 32'(bus1.rsp_id), 32'd0);
      check("rst_busy", 32'(busy1), 32'd0);
      tick();
      bus1.req_valid = '0;
      rst = 1'b0;
      tick();

      // Single requests: tree truth pinned by hand.
      single(1, 8'h05, 8'hFF, 1'b1, "t1");
      single(0, 8'h03, 8'hFF, 1'b0, "t2a");
      single(2, 8'h50, 8'h50, 1'b1, "t2b");
      single(3, 8'hFF, 8'h0F, 1'b1, "t2c");

      // All requesters continuously valid: rotation 0,1,2,3,0.
      grant_log.delete();
      bus1.req_x = 32'h44_33_22_11;
      bus1.req_y = 32'hFF_FF_FF_FF;
      bus1.req_valid = '1;
      n = 0;
      while (grant_log.size() < 5 && n < 40) begin
         tick();
         n++;
      end
      bus1.req_valid = '0;
      check("t3_grant_count", 32'(grant_log.size()), 32'd5);
      for (int i = 0; i < 5 && i < grant_log.size(); i++)
         check($sformatf("t3_order_%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));
      wait_rsp1("t3_timeout");
      tick();
      tick();

      // Response back-pressure while another requester waits.
      bus1.rsp_ready = 1'b0;
      bus1.req_x[15:8] = 8'h0C; bus1.req_y[15:8] = 8'h0C;
      bus1.req_x[23:16] = 8'h90; bus1.req_y[23:16] = 8'h90;
      bus1.req_valid = 4'b0010;
      tick();
      bus1.req_valid = 4'b0110;
      wait_rsp1("t4_timeout");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_hold_valid", 32'(bus1.rsp_valid), 32'd1);
         check("t4_hold_id", 32'(bus1.rsp_id), 32'd1);
         check("t4_hold_out", 32'(bus1.rsp_out), 32'd0);
         check("t4_no_grant", 32'(bus1.req_ready), 32'd0);
      end
      tick();
      bus1.rsp_ready = 1'b1;
      tick();
      @(negedge clk);
      check("t4_next_grant", 32'(bus1.req_ready), 32'b0100);
      tick();
      bus1.req_valid = '0;
      wait_rsp1("t4b_timeout");
      check("t4_id2", 32'(bus1.rsp_id), 32'd2);
      check("t4_out2", 32'(bus1.rsp_out), 32'd1);
      tick();
      tick();

      // SETTLE=3 instance: latency and operand stability.
      bus3.req_x[7:0] = 8'h0A; bus3.req_y[7:0] = 8'h0F;
      bus3.req_valid = 4'b0001;
      @(negedge clk);
      check("t5_grant", 32'(bus3.req_ready), 32'd1);
      tick();
      bus3.req_valid = '0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (!bus3.rsp_valid) begin
            check("t5_eval_x", 32'(eval_x3), 32'h0A);
            check("t5_eval_y", 32'(eval_y3), 32'h0F);
         end
      end while (!bus3.rsp_valid && n < 20);
      check("t5_latency", 32'(n), 32'd4);
      check("t5_id", 32'(bus3.rsp_id), 32'd0);
      check("t5_out", 32'(bus3.rsp_out), 32'd1);
      tick();
      @(negedge clk);
      check("t5_busy_after", 32'(busy3), 32'd0);
      tick();

      // Reset in the middle of SETTLE abandons the operation and clears the pointer.
      bus1.req_x[15:8] = 8'h01; bus1.req_y[15:8] = 8'h01;
      bus1.req_valid = 4'b0010;
      tick();
      bus1.req_valid = '0;
      #2 rst = 1'b1;
      #1;
      check("t6_busy", 32'(busy1), 32'd0);
      check("t6_eval_x", 32'(eval_x1), 32'd0);
      check("t6_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
      check("t6_rsp_id", 32'(bus1.rsp_id), 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t6_no_rsp", 32'(bus1.rsp_valid), 32'd0);
      end
      tick();
      bus1.req_x[7:0] = 8'h22; bus1.req_y[7:0] = 8'h22;
      bus1.req_x[31:24] = 8'h33; bus1.req_y[31:24] = 8'h33;
      bus1.req_valid = 4'b1001;
      @(negedge clk);
      check("t6_grant_from_0", 32'(bus1.req_ready), 32'b0001);
      tick();
      bus1.req_valid = '0;
      wait_rsp1("t6_timeout");
      check("t6_id", 32'(bus1.rsp_id), 32'd0);
      check("t6_out", 32'(bus1.rsp_out), 32'd0);
      tick();
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/complex_sched.md
Name: complex_sched

Overview:
- Round-robin scheduler that shares one combinational AND-OR evaluation tree (8-bit x/y in, 1-bit out) among NREQ requesters.
- Per requester: valid/ready request handshake. One common valid/ready response channel tagged with the requester ID.
- Drives the shared tree's operands from registers, holds them for SETTLE cycles, captures the result, then returns it.
- Sits between client blocks and a single tree instance, so the tree logic is not replicated.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, 2, width of rsp_id; must satisfy 2**ID_W >= NREQ
SETTLE, 1, cycles eval_x/eval_y are held before eval_out is sampled (1..15)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  NREQ  request present, one bit per requester
req_x  in  8*NREQ  x operand; requester i occupies bits [8i+7:8i]
req_y  in  8*NREQ  y operand, same packing as req_x
req_ready  out  NREQ  one-hot grant/accept, combinational from state and req_valid
eval_x  out  8  registered x operand to the shared tree
eval_y  out  8  registered y operand to the shared tree
eval_out  in  1  result from the shared tree
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  ID_W  index of the requester that owns the response
rsp_out  out  1  captured tree result
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, any time): state=IDLE; ptr=0; cnt=0; eval_x=eval_y=0; rsp_valid=0; rsp_id=0; rsp_out=0; req_ready=0.
- Reset during SETTLE or RESP abandons the operation. No response is ever issued for it.
- FSM states: IDLE, SETTLE, RESP.
- IDLE, grant selection:
  - Winner g = first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NREQ.
  - req_ready[g]=1 in that same cycle; all other req_ready bits are 0.
  - req_ready is 0 in SETTLE and RESP.
- IDLE, acceptance (req_valid[g] & req_ready[g]) at edge T:
  - eval_x <= req_x[g]; eval_y <= req_y[g]; rsp_id <= g.
  - cnt <= SETTLE; state <= SETTLE.
- IDLE with no req_valid: remain in IDLE; eval_x/eval_y hold their last values.
- SETTLE:
  - cnt decrements each cycle.
  - On the edge where cnt==1: rsp_out <= eval_out; rsp_valid <= 1; state <= RESP.
  - rsp_valid is therefore first high SETTLE+1 cycles after the accept edge.
- RESP:
  - rsp_valid, rsp_id and rsp_out are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: rsp_valid <= 0; ptr <= (g+1) mod NREQ (wraps from NREQ-1 to 0); state <= IDLE.
  - rsp_ready already high on the first RESP cycle completes the handshake in that cycle.
- No request is accepted in the same cycle as a response handshake. Minimum spacing between accepts is SETTLE+2 cycles.
- Requester obligations: req_x/req_y must be stable while req_valid is high and not yet accepted. Dropping req_valid before acceptance is legal; the slot simply moves to the next valid requester.
- eval_x/eval_y stay constant from the accept edge through the capture edge, so the shared tree sees stable operands for SETTLE full cycles.
- Fairness: a continuously requesting requester is served within NREQ grants.

Test Plan:
1. Reset, then req_valid[1]=1 with x=0x05, y=0xFF, SETTLE=1, rsp_ready=1 -> req_ready=0010 in that cycle; eval_x=0x05 next cycle; rsp_valid one cycle later with rsp_id=1, rsp_out=1; busy low afterwards.
2. Single request with x=0x03, y=0xFF -> rsp_out=0 (only the lowest pair set, the upper pair product is 0). Request with x=0x50, y=0x50 -> rsp_out=1.
3. All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; ptr wraps from 3 to 0; no requester is granted twice in a row while others wait.
4. rsp_ready=0 for 5 cycles during RESP -> rsp_valid, rsp_id and rsp_out are constant; req_ready=0000 throughout; the pending requester is granted only after the handshake.
5. SETTLE=3 -> accept-to-rsp_valid latency is exactly 4 cycles; eval_x/eval_y unchanged across the window.
6. rst asserted mid-SETTLE, asynchronously between edges -> outputs go to reset values immediately; no rsp_valid follows; after release, the next grant starts from requester 0.
